// File: rtl/vscale_trace_checker_if.sv
// Retire-event payload type and the retire/golden stream interface between
// the pipeline/golden source and vscale_trace_checker.
package vscale_trace_checker_pkg;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            wr_en;
    logic            is_freg;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] data;
  } trace_ev_t;
endpackage

interface vscale_trace_checker_if;
  import vscale_trace_checker_pkg::*;

  logic            ret_valid;
  logic [XLEN-1:0] ret_pc;
  logic [XLEN-1:0] ret_inst;
  logic            ret_wr_en;
  logic            ret_is_freg;
  logic [RW-1:0]   ret_rd;
  logic [XLEN-1:0] ret_data;

  logic            exp_valid;
  logic            exp_ready;
  logic [XLEN-1:0] exp_pc;
  logic [XLEN-1:0] exp_inst;
  logic            exp_wr_en;
  logic            exp_is_freg;
  logic [RW-1:0]   exp_rd;
  logic [XLEN-1:0] exp_data;
  logic            exp_last;

  modport master (
    output ret_valid, ret_pc, ret_inst, ret_wr_en, ret_is_freg, ret_rd, ret_data,
    output exp_valid, exp_pc, exp_inst, exp_wr_en, exp_is_freg, exp_rd, exp_data, exp_last,
    input  exp_ready
  );

  modport slave (
    input  ret_valid, ret_pc, ret_inst, ret_wr_en, ret_is_freg, ret_rd, ret_data,
    input  exp_valid, exp_pc, exp_inst, exp_wr_en, exp_is_freg, exp_rd, exp_data, exp_last,
    output exp_ready
  );
endinterface

// File: rtl/vscale_trace_checker.sv
// In-order retirement trace checker: buffers retire events in a small FIFO and
// compares them against a golden valid/ready stream, latching the first divergence.
module vscale_trace_checker
  import vscale_trace_checker_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  vscale_trace_checker_if.slave bus,
  output logic [CNT_W-1:0]      checked_count,
  output logic                  mismatch,
  output logic [XLEN-1:0]       mismatch_pc,
  output logic [2:0]            mismatch_field,
  output logic                  done,
  output logic                  busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [2:0] F_NONE  = 3'd0;
  localparam logic [2:0] F_PC    = 3'd1;
  localparam logic [2:0] F_INST  = 3'd2;
  localparam logic [2:0] F_WR    = 3'd3;
  localparam logic [2:0] F_RD    = 3'd4;
  localparam logic [2:0] F_DATA  = 3'd5;
  localparam logic [2:0] F_OVF   = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAIL, S_DONE} state_t;

  state_t state, state_next;

  trace_ev_t mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;

  trace_ev_t ret_ev, exp_ev, head_ev;
  logic      pop, push, overflow;
  logic [2:0] cmp_code;

  // Golden comparison; x0 writes are normalised to "no write" on both sides.
  function automatic logic [2:0] compare(input trace_ev_t a, input trace_ev_t b);
    logic a_wr, b_wr;
    logic [2:0] code;
    a_wr = a.wr_en && (a.is_freg || (a.rd != '0));
    b_wr = b.wr_en && (b.is_freg || (b.rd != '0));
    code = F_NONE;
    if (a.pc != b.pc)                                 code = F_PC;
    else if (a.inst != b.inst)                        code = F_INST;
    else if ({a_wr, a.is_freg} != {b_wr, b.is_freg})  code = F_WR;
    else if (a_wr && (a.rd != b.rd))                  code = F_RD;
    else if (a_wr && (a.data != b.data))              code = F_DATA;
    return code;
  endfunction

  assign ret_ev = '{pc: bus.ret_pc, inst: bus.ret_inst, wr_en: bus.ret_wr_en,
                    is_freg: bus.ret_is_freg, rd: bus.ret_rd, data: bus.ret_data};
  assign exp_ev = '{pc: bus.exp_pc, inst: bus.exp_inst, wr_en: bus.exp_wr_en,
                    is_freg: bus.exp_is_freg, rd: bus.exp_rd, data: bus.exp_data};
  assign head_ev    = mem[rd_ptr[AW-1:0]];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bus.exp_ready = pop;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_next = S_RUN;
        S_RUN: begin
          if (pop && (cmp_code != F_NONE)) state_next = S_FAIL;
          else if (pop && bus.exp_last)    state_next = S_DONE;
          else if (overflow)               state_next = S_FAIL;
        end
        default: state_next = state;
      endcase
    end
  end

  // Handshake decode; a full FIFO may still accept a push when it pops the same cycle
  always_comb begin
    pop      = 1'b0;
    push     = 1'b0;
    overflow = 1'b0;
    cmp_code = compare(head_ev, exp_ev);
    if (state == S_RUN) begin
      pop      = !fifo_empty && bus.exp_valid;
      push     = bus.ret_valid && (!fifo_full || pop);
      overflow = bus.ret_valid && fifo_full && !pop;
    end
  end

  // FIFO storage carries no reset; pointers define occupancy
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= ret_ev;
  end

  // Pointers and registered result outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      checked_count  <= '0;
      mismatch       <= 1'b0;
      mismatch_pc    <= '0;
      mismatch_field <= F_NONE;
      done           <= 1'b0;
      busy           <= 1'b0;
    end else begin
      busy <= (state_next == S_RUN);
      if ((state == S_IDLE) && enable) begin
        wr_ptr         <= '0;
        rd_ptr         <= '0;
        checked_count  <= '0;
        mismatch       <= 1'b0;
        mismatch_pc    <= '0;
        mismatch_field <= F_NONE;
        done           <= 1'b0;
      end else if (state == S_RUN) begin
        if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        if (pop) begin
          if (cmp_code != F_NONE) begin
            mismatch       <= 1'b1;
            mismatch_field <= cmp_code;
            mismatch_pc    <= head_ev.pc;
          end else begin
            checked_count <= checked_count + CNT_W'(1);
            if (bus.exp_last) done <= 1'b1;
          end
        end else if (overflow) begin
          mismatch       <= 1'b1;
          mismatch_field <= F_OVF;
          mismatch_pc    <= bus.ret_pc;
        end
      end
    end
  end

endmodule
